// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the processor ALU datapath: opcode encodings plus
// the elaboration-time helpers used by the forwarding word selector
// (muxn_pipe_alu).
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // Legal register-stage counts for the word selector: MIN..MAX inclusive.
    localparam int MUXN_LATENCY_MIN = 1;
    localparam int MUXN_LATENCY_MAX = 2;

    // Number of select bits resolved by the first stage of a two-stage
    // selector: ceil(selw/2).
    function automatic int muxn_k(input int selw);
        return (selw + 1) / 2;
    endfunction

    // Nodes needed at tree level lvl when the leaf level holds n words:
    // ceil(n / 2^lvl). Nodes past this count would only ever carry zero.
    function automatic int muxn_nodes(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/muxw2_1_alu.sv
// ---------------------------------------------------------------------------
// muxw2_1_alu
// Combinational W-bit 2:1 word mux; the building block of both selector
// tree stages in muxn_pipe_alu.
//   i_a   : word chosen when i_sel = 0
//   i_b   : word chosen when i_sel = 1
//   i_sel : select
//   o_y   : selected word
// ---------------------------------------------------------------------------
module muxw2_1_alu
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/muxn_pipe_alu.sv
// ---------------------------------------------------------------------------
// muxn_pipe_alu
// N-way, W-bit pipelined word selector feeding the ALU operand latch.
// Built as a tree of 2:1 word muxes with one or two register stages.
// Carries a valid bit with the data, honours stall/flush, and flags selects
// that fall outside the N populated inputs.
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; beats every other input
//   in_valid  : sel/data this cycle describe a real operation
//   sel       : index of the word to select (SELW bits)
//   data      : flattened inputs, word k = data[k*W +: W]
//   stall     : hold every register; the presented op is not accepted
//   flush     : clear all valid bits and sel_err; beats stall
//   out_valid : out carries a completed selection
//   out       : selected word (holds the last valid result otherwise)
//   sel_err   : with out_valid, the selection had sel >= N (out is 0)
// ---------------------------------------------------------------------------
module muxn_pipe_alu
    import alu_pkg::*;
#(
    parameter  int W       = 64,
    parameter  int N       = 4,
    parameter  int LATENCY = 1,
    localparam int SELW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  data,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [W-1:0]    out,
    output logic            sel_err
);

    // Anything outside MIN..MAX is clamped so elaboration stays well defined.
    localparam int  LAT_EFF   = (LATENCY >= MUXN_LATENCY_MAX) ? MUXN_LATENCY_MAX
                                                              : MUXN_LATENCY_MIN;
    localparam bit  TWO_STAGE = (LAT_EFF == MUXN_LATENCY_MAX);
    // Depth of the input-side tree: all select bits for one stage, the low
    // half for two stages.
    localparam int  K         = TWO_STAGE ? muxn_k(SELW) : SELW;
    localparam logic [SELW:0] N_LIMIT = (SELW + 1)'(N);

    genvar gi, gk;

    logic w_sel_oor;
    assign w_sel_oor = ({1'b0, sel} >= N_LIMIT);

    // -----------------------------------------------------------------------
    // Input-side tree. Level 0 holds the N input words; level gi reduces
    // pairs using sel[gi-1]. A node whose right child does not exist takes 0
    // there, so an out-of-range sel walks into a zero and the selected word
    // is 0 without any extra gating.
    // -----------------------------------------------------------------------
    for (gi = 0; gi <= K; gi++) begin : g_lo
        localparam int CNT = muxn_nodes(N, gi);
        logic [W-1:0] w_node [CNT];

        if (gi == 0) begin : g_leaf
            for (gk = 0; gk < N; gk++) begin : g_w
                assign w_node[gk] = data[gk*W +: W];
            end
        end else begin : g_lvl
            localparam int PCNT = muxn_nodes(N, gi - 1);
            for (gk = 0; gk < CNT; gk++) begin : g_m
                if (2*gk + 1 < PCNT) begin : g_pair
                    muxw2_1_alu #(.W(W)) u_mux (
                        .i_a   (g_lo[gi-1].w_node[2*gk]),
                        .i_b   (g_lo[gi-1].w_node[2*gk+1]),
                        .i_sel (sel[gi-1]),
                        .o_y   (w_node[gk])
                    );
                end else begin : g_half
                    muxw2_1_alu #(.W(W)) u_mux (
                        .i_a   (g_lo[gi-1].w_node[2*gk]),
                        .i_b   ('0),
                        .i_sel (sel[gi-1]),
                        .o_y   (w_node[gk])
                    );
                end
            end
        end
    end

    // Result presented to the output register, with its valid and range flag.
    logic [W-1:0] w_res;
    logic         w_res_valid;
    logic         w_res_err;

    if (!TWO_STAGE) begin : g_one
        assign w_res       = g_lo[K].w_node[0];
        assign w_res_valid = in_valid;
        assign w_res_err   = w_sel_oor;
    end else begin : g_two
        localparam int NG = muxn_nodes(N, K);   // group words kept in stage 1
        localparam int DU = SELW - K;           // select bits left for stage 2

        logic [W-1:0] r_grp [NG];
        logic         r_s1_valid;
        logic         r_s1_err;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1_valid <= 1'b0;
                r_s1_err   <= 1'b0;
                for (int j = 0; j < NG; j++) begin
                    r_grp[j] <= '0;
                end
            end else if (flush) begin
                r_s1_valid <= 1'b0;
                r_s1_err   <= 1'b0;
            end else if (!stall) begin
                r_s1_valid <= in_valid;
                r_s1_err   <= in_valid & w_sel_oor;
                // Group words only move with a real op; bubbles leave them.
                if (in_valid) begin
                    for (int j = 0; j < NG; j++) begin
                        r_grp[j] <= g_lo[K].w_node[j];
                    end
                end
            end
        end

        assign w_res_valid = r_s1_valid;
        assign w_res_err   = r_s1_err;

        if (DU > 0) begin : g_hi
            logic [DU-1:0] r_sel_hi;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sel_hi <= '0;
                end else if (!flush && !stall && in_valid) begin
                    r_sel_hi <= sel[SELW-1:K];
                end
            end

            // Stage-2 tree over the registered group words; missing groups
            // read as zero, same as in the input-side tree.
            for (gi = 0; gi <= DU; gi++) begin : g_up
                localparam int CNT = muxn_nodes(NG, gi);
                logic [W-1:0] w_node [CNT];

                if (gi == 0) begin : g_leaf
                    for (gk = 0; gk < NG; gk++) begin : g_w
                        assign w_node[gk] = r_grp[gk];
                    end
                end else begin : g_lvl
                    localparam int PCNT = muxn_nodes(NG, gi - 1);
                    for (gk = 0; gk < CNT; gk++) begin : g_m
                        if (2*gk + 1 < PCNT) begin : g_pair
                            muxw2_1_alu #(.W(W)) u_mux (
                                .i_a   (g_up[gi-1].w_node[2*gk]),
                                .i_b   (g_up[gi-1].w_node[2*gk+1]),
                                .i_sel (r_sel_hi[gi-1]),
                                .o_y   (w_node[gk])
                            );
                        end else begin : g_half
                            muxw2_1_alu #(.W(W)) u_mux (
                                .i_a   (g_up[gi-1].w_node[2*gk]),
                                .i_b   ('0),
                                .i_sel (r_sel_hi[gi-1]),
                                .o_y   (w_node[gk])
                            );
                        end
                    end
                end
            end

            assign w_res = g_up[DU].w_node[0];
        end else begin : g_nohi
            // N = 2: stage 1 already resolved the whole select.
            assign w_res = r_grp[0];
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    logic [W-1:0] r_out;
    logic         r_out_valid;
    logic         r_sel_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (!stall) begin
            r_out_valid <= w_res_valid;
            r_sel_err   <= w_res_valid & w_res_err;
            if (w_res_valid) begin
                r_out <= w_res;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: doc/muxn_pipe_alu.md
Name: muxn_pipe_alu

Overview:
- Parametrised N-way, W-bit word selector for the ALU/forwarding datapath of the pipelined processor.
- Built as a tree of 2:1 word muxes, with 1 or 2 register stages.
- Carries a valid bit alongside the data, honours pipeline stall and flush, and flags out-of-range selects.
- Sits between the register-read/forwarding sources and the ALU operand latch.

Parameters:
W, 64, data word width in bits
N, 4, number of input words (2..16, need not be a power of two)
LATENCY, 1, register stages from input to output (1 or 2)
SELW, $clog2(N), select width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  this cycle's sel/data are a real operation
sel  input  SELW  word index to select
data  input  N*W  flattened inputs; word k = data[k*W +: W]
stall  input  1  freeze all internal and output registers
flush  input  1  kill all in-flight operations
out_valid  output  1  out carries a completed selection
out  output  W  selected word
sel_err  output  1  qualified with out_valid; the selection had sel >= N

Behaviour:
- One clock, clk. reset is synchronous and active-high; it takes priority over every other input.
- Reset values:
  - out_valid=0, out=0, sel_err=0.
  - All stage valids=0, all stage data/sel registers=0.
- Latency: an accepted op (in_valid=1, stall=0) appears with out_valid=1 exactly LATENCY cycles later, counting only non-stalled cycles.
- LATENCY=1:
  - The full tree is combinational.
  - Single register: out <= data[sel], out_valid <= in_valid, sel_err <= (sel >= N).
- LATENCY=2:
  - Let K = ceil(SELW/2).
  - Stage 1 reduces groups of 2^K words using sel[K-1:0]. It registers ceil(N/2^K) group words, sel[SELW-1:K], the valid bit and the range flag.
  - Stage 2 selects among the groups using the registered upper sel bits, then registers out.
  - Missing words in a partial last group read as 0.
- Out-of-range select (sel >= N):
  - Selected word is forced to 0.
  - sel_err=1 in the same cycle as the matching out_valid.
  - No other side effect.
- Invalid ops: when stage valid=0, that stage's data register holds its previous value. out holds the last valid result, and out_valid=0.
- Stall: with stall=1 (and reset=0, flush=0), every register holds, including out, out_valid and sel_err. Inputs presented during stall are not accepted.
- Flush:
  - flush=1 clears every valid bit (stage 1 and output) and sel_err on the next edge.
  - Data registers are unchanged.
  - flush beats stall.
  - The op presented with flush=1 is discarded.
- Simultaneous stall and in_valid: the op is not accepted. The upstream pipeline must re-present it.
- Reset mid-operation: all in-flight ops are lost, and out_valid=0 on the cycle after reset is sampled.
- Back-to-back ops: throughput is one op per non-stalled cycle, with no bubbles.
- Width rule: no arithmetic. Output width equals W exactly, and select-bit slicing uses SELW bits only.

Decomposition:
- Shared package alu_pkg: the LATENCY legal-values constant and a function computing K from SELW. alu_pkg already holds ALU opcode typedefs; these go there.
- One natural sub-module, muxw2_1_alu: W-bit 2:1 word mux, combinational, parametrised on W. Both tree stages are generate-instantiated from it.
- Registers live in muxn_pipe_alu only.

Test Plan:
1. W=64, N=4, LATENCY=1: data words {0x00000000_0000FB65, 0x6590, 0x100, 0x80}; sel 0,1,2,3 on consecutive cycles with in_valid=1 -> out = 0xFB65, 0x6590, 0x100, 0x80 on the following cycles, out_valid=1 each cycle, sel_err=0.
2. W=32, N=5, LATENCY=2: sel=4 then sel=6 (word4=0xDEADBEEF) -> after 2 cycles out=0xDEADBEEF, sel_err=0; next cycle out=0, sel_err=1, out_valid=1.
3. LATENCY=2, stream sel 0,1,2 back-to-back; assert stall for 2 cycles after the second accept -> out, out_valid and stage-1 contents frozen during stall; all three results emerge in order with no duplicate or lost op.
4. LATENCY=2, two ops in flight, flush=1 together with stall=1 for one cycle -> next cycle out_valid=0, no further valid outputs; out retains its prior value.
5. Apply reset for one cycle while an op is in stage 1 -> out=0, out_valid=0, sel_err=0 after the edge; an op accepted on the cycle after reset completes normally.
6. in_valid=0 with sel=1 and varying data -> out_valid stays 0 and out unchanged from the last valid result.
